riscv_mc_control: RTL and testbench
===================================

# riscv_mc_control

Main control FSM for the RV32I multi-cycle core. It sequences one shared ALU, one unified memory port, the register file and the PC/IR registers across FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It drives the 2-bit `alu_op` consumed by the `aluCu` ALU control unit, and resolves branch conditions from the ALU flags. Illegal or trapping instructions halt the core.

## Interface
- `TRAP_ON_SYSTEM`, default 1: 1 sends opcode 1110011 (ECALL/EBREAK/CSR) to TRAP; 0 retires it as a NOP.
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst_n`  in  1  reset, **synchronous, active-low**.
- `Instruction`  in  32  IR contents, stable from DECODE until the next FETCH.
- `mem_ready`  in  1  memory ack for the current `mem_req`; ignored while `mem_req`=0.
- `alu_zero`, `alu_lt`, `alu_ltu`  in  1 each  ALU flags for rs1−rs2.
- `alu_op`  out  2  00 NOP, 01 SUB, 10 ADD, 11 FUNCT.
- `alu_src_a`  out  2  00 PC, 01 old PC, 10 rs1, 11 zero.
- `alu_src_b`  out  2  00 rs2, 01 imm, 10 const 4.
- `addr_sel`  out  1  memory address: 0 PC, 1 ALU-out register.
- `mem_req`, `mem_we`  out  1 each  memory request and write enable.
- `ir_write`, `pc_write`  out  1 each  register load enables.
- `pc_src`  out  1  0 live ALU result, 1 ALU-out register.
- `reg_write`  out  1  register file write.
- `wb_sel`  out  2  00 ALU-out, 01 memory data register, 10 PC (already +4), 11 imm.
- `retire`  out  1  one-cycle pulse on the last cycle of every instruction.
- `halt`  out  1  sticky trap indicator.
- `state`  out  4  current state, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, WB_ALU 4, MEM_ADDR 5, MEM_RD 6, WB_MEM 7, MEM_WR 8, BRANCH 9, JAL 10, JALR 11, LUI 12, AUIPC 13, TRAP 15. Encoding 14 → TRAP.
- Any output not listed for a state is 0.
- **FETCH**
  - Drives: `mem_req`=1, `addr_sel`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=10.
  - `ir_write` = `pc_write` = `mem_ready`, with `pc_src`=0.
  - Stays in FETCH until `mem_ready`=1, then → DECODE.
- **DECODE**
  - Drives `alu_src_a`=01, `alu_src_b`=01, `alu_op`=10, so ALU-out captures the branch/JAL/AUIPC target.
  - Next state by `Instruction[6:0]`:
    - 0110011 → EXEC_R; 0010011 → EXEC_I.
    - 0000011 or 0100011 → MEM_ADDR.
    - 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR.
    - 0110111 → LUI; 0010111 → AUIPC.
    - 0001111 → FETCH, with `retire` pulsed in DECODE.
    - 1110011 → TRAP, or FETCH with `retire` when `TRAP_ON_SYSTEM`=0.
    - Any other opcode → TRAP.
- **EXEC_R**: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=11; → WB_ALU.
- **EXEC_I**: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=11; → WB_ALU.
- **WB_ALU**: `reg_write`=1, `wb_sel`=00, `retire`; → FETCH.
- **MEM_ADDR**: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10; → MEM_RD if `Instruction[5]`=0, else MEM_WR.
- **MEM_RD**: `mem_req`=1, `addr_sel`=1; holds until `mem_ready`, then → WB_MEM.
- **WB_MEM**: `reg_write`=1, `wb_sel`=01, `retire`; → FETCH.
- **MEM_WR**: `mem_req`=1, `mem_we`=1, `addr_sel`=1; holds until `mem_ready`, then `retire` and → FETCH.
- **BRANCH**
  - Drives `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `pc_src`=1, `retire`; → FETCH.
  - `pc_write` = taken, decoded from funct3: BEQ `zero`, BNE `!zero`, BLT `lt`, BGE `!lt`, BLTU `ltu`, BGEU `!ltu`.
  - funct3 010 or 011 → TRAP instead, with no `pc_write` and no `retire`.
- **JAL**: `reg_write`=1, `wb_sel`=10, `pc_write`=1, `pc_src`=1, `retire`; → FETCH.
- **JALR**
  - Drives `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10, `pc_src`=0, `pc_write`=1, `reg_write`=1, `wb_sel`=10, `retire`; → FETCH.
  - The datapath clears target bit 0.
- **LUI**: `reg_write`=1, `wb_sel`=11, `retire`; → FETCH.
- **AUIPC**: `reg_write`=1, `wb_sel`=00, `retire`; → FETCH.
- **TRAP**: `halt`=1, all other outputs 0. Only reset exits.

## Timing
- Outputs are decoded combinationally from `state`. `Instruction` is decoded only in DECODE, BRANCH and MEM_ADDR. Only the FETCH `ir_write`/`pc_write` depend on `mem_ready` (Mealy).
- Memory handshake:
  - `mem_req`, `mem_we` and `addr_sel` stay constant until the cycle `mem_ready`=1.
  - Zero-wait acks (same cycle as the request) are legal.
  - No timeout.
- Latency with zero-wait memory:
  - R/I-type 4 cycles; load 5; store 4.
  - Branch, JAL, JALR, LUI, AUIPC 3; FENCE 2.
  - Each memory wait cycle adds 1.
- Reset:
  - While `rst_n`=0, all outputs are forced to 0, including `halt`; `state` reads 0.
  - The first clock edge with `rst_n`=0 loads FETCH, including mid-instruction and mid-handshake; no write is committed.
  - The first cycle after reset release is FETCH with `mem_req`=1.

## Structure
- Shared header `riscv_defines.vh` holds:
  - opcode constants;
  - `alu_op`, `alu_src_a/b`, `wb_sel` and `pc_src` encodings;
  - state encodings (shared with the datapath and testbench).
- One sub-module, `branch_cond`, combinational: (funct3, `alu_zero`, `alu_lt`, `alu_ltu`) → {`taken`, `illegal`}.

## Test plan
- ADD x3,x1,x2 (0x002081B3), `mem_ready` tied 1:
  - `alu_op` sequence 10, 10, 11, 00;
  - `reg_write` and `retire` only in cycle 4; next cycle is FETCH.
- LW with `mem_ready` delayed 3 cycles in MEM_RD:
  - `mem_req`=1 and `addr_sel`=1 held all 4 MEM_RD cycles;
  - WB_MEM `wb_sel`=01; total 8 cycles.
- BEQ with `alu_zero`=1 → `pc_write`=1, `pc_src`=1 in BRANCH. BNE with `alu_zero`=1 → `pc_write`=0. Both retire in 3 cycles.
- JALR (0x000080E7) → a single cycle with `pc_write`=1, `reg_write`=1, `wb_sel`=10, `pc_src`=0.
- Instruction 0x00000000 → TRAP; `halt`=1 and no `mem_req` for 100 cycles. Pulsing `rst_n` low → FETCH and `halt`=0.
- `rst_n` low during MEM_WR wait → all outputs 0 in the reset cycles, no `retire`, FETCH after release. Also check ECALL with `TRAP_ON_SYSTEM`=0 retires in 2 cycles.

Source files
------------

// File: rtl/riscv_mc_control_pkg.sv
// Encodings shared by the multi-cycle RV32I control FSM, its datapath and testbench.
// Opcodes, ALU/mux select codes, branch funct3 values and state numbers.
package riscv_mc_control_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_WB_ALU   = 4'd4,
      S_MEM_ADDR = 4'd5,
      S_MEM_RD   = 4'd6,
      S_WB_MEM   = 4'd7,
      S_MEM_WR   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12,
      S_AUIPC    = 4'd13,
      S_TRAP     = 4'd15
   } ctrl_state_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] ALU_NOP   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_ADD   = 2'b10;
   localparam logic [1:0] ALU_FUNCT = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MDR    = 2'b01;
   localparam logic [1:0] WB_PC     = 2'b10;
   localparam logic [1:0] WB_IMM    = 2'b11;

   localparam logic PC_SRC_ALU    = 1'b0;
   localparam logic PC_SRC_ALUOUT = 1'b1;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/riscv_mc_control_branch_cond.sv
// Branch resolver: turns funct3 and the rs1-rs2 ALU flags into taken/illegal.
module riscv_mc_control_branch_cond
   import riscv_mc_control_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       alu_zero,
   input  logic       alu_lt,
   input  logic       alu_ltu,
   output logic       taken,
   output logic       illegal
);

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         F3_BEQ:  taken = alu_zero;
         F3_BNE:  taken = !alu_zero;
         F3_BLT:  taken = alu_lt;
         F3_BGE:  taken = !alu_lt;
         F3_BLTU: taken = alu_ltu;
         F3_BGEU: taken = !alu_ltu;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/riscv_mc_control.sv
// Main control FSM of the RV32I multi-cycle core: sequences ALU, memory port,
// register file and PC/IR across fetch, decode, execute, memory and writeback.
module riscv_mc_control
   import riscv_mc_control_pkg::*;
#(
   parameter bit TRAP_ON_SYSTEM = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Instruction,
   input  logic        mem_ready,
   input  logic        alu_zero,
   input  logic        alu_lt,
   input  logic        alu_ltu,
   output logic [1:0]  alu_op,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        addr_sel,
   output logic        mem_req,
   output logic        mem_we,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        reg_write,
   output logic [1:0]  wb_sel,
   output logic        retire,
   output logic        halt,
   output logic [3:0]  state
);

   ctrl_state_e state_q, state_d;
   logic        br_taken, br_illegal;
   logic        instr_unused;

   assign instr_unused = ^{Instruction[31:15], Instruction[11:7]};

   riscv_mc_control_branch_cond u_branch_cond (
      .funct3   (Instruction[14:12]),
      .alu_zero (alu_zero),
      .alu_lt   (alu_lt),
      .alu_ltu  (alu_ltu),
      .taken    (br_taken),
      .illegal  (br_illegal)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   assign state = rst_n ? state_q : S_FETCH;

   // Reset gates every output to zero so nothing is committed mid-instruction.
   always_comb begin
      state_d   = state_q;
      alu_op    = ALU_NOP;
      alu_src_a = SRCA_PC;
      alu_src_b = SRCB_RS2;
      addr_sel  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_SRC_ALU;
      reg_write = 1'b0;
      wb_sel    = WB_ALUOUT;
      retire    = 1'b0;
      halt      = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = SRCB_FOUR;
               alu_op    = ALU_ADD;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
               if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_IMM;
               alu_op    = ALU_ADD;
               case (Instruction[6:0])
                  OP_R:               state_d = S_EXEC_R;
                  OP_IMM:             state_d = S_EXEC_I;
                  OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                  OP_BRANCH:          state_d = S_BRANCH;
                  OP_JAL:             state_d = S_JAL;
                  OP_JALR:            state_d = S_JALR;
                  OP_LUI:             state_d = S_LUI;
                  OP_AUIPC:           state_d = S_AUIPC;
                  OP_FENCE: begin
                     retire  = 1'b1;
                     state_d = S_FETCH;
                  end
                  OP_SYSTEM: begin
                     if (TRAP_ON_SYSTEM) begin
                        state_d = S_TRAP;
                     end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                     end
                  end
                  default:            state_d = S_TRAP;
               endcase
            end
            S_EXEC_R: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_RS2;
               alu_op    = ALU_FUNCT;
               state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_IMM;
               alu_op    = ALU_FUNCT;
               state_d   = S_WB_ALU;
            end
            S_WB_ALU: begin
               reg_write = 1'b1;
               wb_sel    = WB_ALUOUT;
               retire    = 1'b1;
               state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_IMM;
               alu_op    = ALU_ADD;
               state_d   = Instruction[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               if (mem_ready) state_d = S_WB_MEM;
            end
            S_WB_MEM: begin
               reg_write = 1'b1;
               wb_sel    = WB_MDR;
               retire    = 1'b1;
               state_d   = S_FETCH;
            end
            S_MEM_WR: begin
               mem_req  = 1'b1;
               mem_we   = 1'b1;
               addr_sel = 1'b1;
               if (mem_ready) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end
            // An illegal funct3 still drives the compare but commits nothing.
            S_BRANCH: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_RS2;
               alu_op    = ALU_SUB;
               pc_src    = PC_SRC_ALUOUT;
               if (br_illegal) begin
                  state_d = S_TRAP;
               end else begin
                  pc_write = br_taken;
                  retire   = 1'b1;
                  state_d  = S_FETCH;
               end
            end
            S_JAL: begin
               reg_write = 1'b1;
               wb_sel    = WB_PC;
               pc_write  = 1'b1;
               pc_src    = PC_SRC_ALUOUT;
               retire    = 1'b1;
               state_d   = S_FETCH;
            end
            S_JALR: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_IMM;
               alu_op    = ALU_ADD;
               pc_src    = PC_SRC_ALU;
               pc_write  = 1'b1;
               reg_write = 1'b1;
               wb_sel    = WB_PC;
               retire    = 1'b1;
               state_d   = S_FETCH;
            end
            S_LUI: begin
               reg_write = 1'b1;
               wb_sel    = WB_IMM;
               retire    = 1'b1;
               state_d   = S_FETCH;
            end
            S_AUIPC: begin
               reg_write = 1'b1;
               wb_sel    = WB_ALUOUT;
               retire    = 1'b1;
               state_d   = S_FETCH;
            end
            default: begin
               halt    = 1'b1;
               state_d = S_TRAP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_mc_control.sv
// Self-checking bench for riscv_mc_control: per-instruction cycle-sequence model
// compared every cycle, plus literal checks of the directed scenarios.
module tb_riscv_mc_control;

   typedef struct packed {
      logic [1:0] alu_op;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic       addr_sel;
      logic       mem_req;
      logic       mem_we;
      logic       ir_write;
      logic       pc_write;
      logic       pc_src;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       retire;
      logic       halt;
      logic [3:0] state;
   } outs_t;

   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_I   = 7'b0010011;
   localparam logic [6:0] OPC_LD  = 7'b0000011;
   localparam logic [6:0] OPC_ST  = 7'b0100011;
   localparam logic [6:0] OPC_BR  = 7'b1100011;
   localparam logic [6:0] OPC_JAL = 7'b1101111;
   localparam logic [6:0] OPC_JR  = 7'b1100111;
   localparam logic [6:0] OPC_LUI = 7'b0110111;
   localparam logic [6:0] OPC_AUI = 7'b0010111;
   localparam logic [6:0] OPC_FEN = 7'b0001111;
   localparam logic [6:0] OPC_SYS = 7'b1110011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] Instruction;
   logic        mem_ready, alu_zero, alu_lt, alu_ltu;

   logic [1:0]  d_alu_op, d_src_a, d_src_b, d_wb_sel;
   logic        d_addr_sel, d_mem_req, d_mem_we, d_ir_write, d_pc_write, d_pc_src;
   logic        d_reg_write, d_retire, d_halt;
   logic [3:0]  d_state;
   logic [1:0]  z_alu_op, z_src_a, z_src_b, z_wb_sel;
   logic        z_addr_sel, z_mem_req, z_mem_we, z_ir_write, z_pc_write, z_pc_src;
   logic        z_reg_write, z_retire, z_halt;
   logic [3:0]  z_state;

   outs_t act, act0, exp_cur;
   bit    exp_valid = 1'b0;
   bit    g_noise   = 1'b0;
   logic [31:0] g_instr = '0;
   logic  g_z = 1'b0, g_lt = 1'b0, g_ltu = 1'b0;
   int    checks = 0, passes = 0, cyc = 0;
   outs_t hist[$];
   outs_t hist0[$];
   logic [6:0] legal_ops[10] = '{OPC_R, OPC_I, OPC_LD, OPC_ST, OPC_BR,
                                 OPC_JAL, OPC_JR, OPC_LUI, OPC_AUI, OPC_FEN};

   riscv_mc_control dut (
      .clk(clk), .rst_n(rst_n), .Instruction(Instruction), .mem_ready(mem_ready),
      .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
      .alu_op(d_alu_op), .alu_src_a(d_src_a), .alu_src_b(d_src_b),
      .addr_sel(d_addr_sel), .mem_req(d_mem_req), .mem_we(d_mem_we),
      .ir_write(d_ir_write), .pc_write(d_pc_write), .pc_src(d_pc_src),
      .reg_write(d_reg_write), .wb_sel(d_wb_sel), .retire(d_retire),
      .halt(d_halt), .state(d_state)
   );

   riscv_mc_control #(.TRAP_ON_SYSTEM(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .Instruction(Instruction), .mem_ready(mem_ready),
      .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
      .alu_op(z_alu_op), .alu_src_a(z_src_a), .alu_src_b(z_src_b),
      .addr_sel(z_addr_sel), .mem_req(z_mem_req), .mem_we(z_mem_we),
      .ir_write(z_ir_write), .pc_write(z_pc_write), .pc_src(z_pc_src),
      .reg_write(z_reg_write), .wb_sel(z_wb_sel), .retire(z_retire),
      .halt(z_halt), .state(z_state)
   );

   assign act  = '{d_alu_op, d_src_a, d_src_b, d_addr_sel, d_mem_req, d_mem_we, d_ir_write,
                   d_pc_write, d_pc_src, d_reg_write, d_wb_sel, d_retire, d_halt, d_state};
   assign act0 = '{z_alu_op, z_src_a, z_src_b, z_addr_sel, z_mem_req, z_mem_we, z_ir_write,
                   z_pc_write, z_pc_src, z_reg_write, z_wb_sel, z_retire, z_halt, z_state};

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (exp_valid) begin
         checks++;
         if (act === exp_cur) passes++;
         else $display("[TB] FAIL cycle %0d outputs: got %h want %h (state want %0d)",
                       cyc, act, exp_cur, exp_cur.state);
         hist.push_back(act);
         hist0.push_back(act0);
      end
   end

   // Expected outputs of one cycle spent in state st, straight from the output table.
   function automatic outs_t ph(input int st, input bit rdy, input bit tk);
      outs_t o;
      o = '0;
      o.state = st[3:0];
      case (st)
         0:  begin o.mem_req = 1; o.alu_src_b = 2; o.alu_op = 2; o.ir_write = rdy; o.pc_write = rdy; end
         1:  begin o.alu_src_a = 1; o.alu_src_b = 1; o.alu_op = 2; end
         2:  begin o.alu_src_a = 2; o.alu_op = 3; end
         3:  begin o.alu_src_a = 2; o.alu_src_b = 1; o.alu_op = 3; end
         4:  begin o.reg_write = 1; o.retire = 1; end
         5:  begin o.alu_src_a = 2; o.alu_src_b = 1; o.alu_op = 2; end
         6:  begin o.mem_req = 1; o.addr_sel = 1; end
         7:  begin o.reg_write = 1; o.wb_sel = 1; o.retire = 1; end
         8:  begin o.mem_req = 1; o.mem_we = 1; o.addr_sel = 1; o.retire = rdy; end
         9:  begin o.alu_src_a = 2; o.alu_op = 1; o.pc_src = 1; o.pc_write = tk; o.retire = 1; end
         10: begin o.reg_write = 1; o.wb_sel = 2; o.pc_write = 1; o.pc_src = 1; o.retire = 1; end
         11: begin o.alu_src_a = 2; o.alu_src_b = 1; o.alu_op = 2; o.pc_write = 1;
                   o.reg_write = 1; o.wb_sel = 2; o.retire = 1; end
         12: begin o.reg_write = 1; o.wb_sel = 3; o.retire = 1; end
         13: begin o.reg_write = 1; o.retire = 1; end
         default: o.halt = 1;
      endcase
      return o;
   endfunction

   function automatic bit noise();
      return g_noise ? bit'($urandom_range(0, 1)) : 1'b1;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
   endtask

   task automatic applyStimulus(input bit rst, input bit rdy, input outs_t e);
      @(posedge clk);
      #1;
      rst_n       = rst;
      mem_ready   = rdy;
      Instruction = g_instr;
      alu_zero    = g_z;
      alu_lt      = g_lt;
      alu_ltu     = g_ltu;
      exp_cur     = e;
      exp_valid   = 1'b1;
      @(negedge clk);
      #1;
   endtask

   task automatic doReset(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, noise(), '0);
   endtask

   // Expands one instruction into its expected cycle list and plays it.
   task automatic runInstr(input logic [31:0] ins, input int fw, input int mw,
                           input logic z, input logic lt, input logic ltu, output bit trapped);
      outs_t d;
      logic [2:0] f3;
      logic c;
      g_instr = ins; g_z = z; g_lt = lt; g_ltu = ltu;
      trapped = 1'b0;
      f3 = ins[14:12];
      for (int i = 0; i < fw; i++) applyStimulus(1, 0, ph(0, 0, 0));
      applyStimulus(1, 1, ph(0, 1, 0));
      d = ph(1, 0, 0);
      case (ins[6:0])
         OPC_R, OPC_I: begin
            applyStimulus(1, noise(), d);
            applyStimulus(1, noise(), ph((ins[6:0] == OPC_R) ? 2 : 3, 0, 0));
            applyStimulus(1, noise(), ph(4, 0, 0));
         end
         OPC_LD: begin
            applyStimulus(1, noise(), d);
            applyStimulus(1, noise(), ph(5, 0, 0));
            for (int i = 0; i < mw; i++) applyStimulus(1, 0, ph(6, 0, 0));
            applyStimulus(1, 1, ph(6, 1, 0));
            applyStimulus(1, noise(), ph(7, 0, 0));
         end
         OPC_ST: begin
            applyStimulus(1, noise(), d);
            applyStimulus(1, noise(), ph(5, 0, 0));
            for (int i = 0; i < mw; i++) applyStimulus(1, 0, ph(8, 0, 0));
            applyStimulus(1, 1, ph(8, 1, 0));
         end
         OPC_BR: begin
            applyStimulus(1, noise(), d);
            if (f3[2:1] == 2'b01) begin
               d = ph(9, 0, 0);
               d.retire = 1'b0;
               applyStimulus(1, noise(), d);
               applyStimulus(1, noise(), ph(15, 0, 0));
               trapped = 1'b1;
            end else begin
               case (f3[2:1])
                  2'b00:   c = z;
                  2'b10:   c = lt;
                  default: c = ltu;
               endcase
               applyStimulus(1, noise(), ph(9, 0, c ^ f3[0]));
            end
         end
         OPC_JAL, OPC_JR, OPC_LUI, OPC_AUI: begin
            applyStimulus(1, noise(), d);
            applyStimulus(1, noise(), ph((ins[6:0] == OPC_JAL) ? 10 : (ins[6:0] == OPC_JR) ? 11 :
                                         (ins[6:0] == OPC_LUI) ? 12 : 13, 0, 0));
         end
         OPC_FEN: begin
            d.retire = 1'b1;
            applyStimulus(1, noise(), d);
         end
         default: begin
            applyStimulus(1, noise(), d);
            applyStimulus(1, noise(), ph(15, 0, 0));
            trapped = 1'b1;
         end
      endcase
   endtask

   function automatic bit isLegal(input logic [6:0] op);
      if (op == OPC_SYS) return 1'b1;
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      bit tr;
      int cnt, cnt2;
      int k;
      logic [31:0] r;
      logic [6:0] op;
      rst_n = 1'b0; mem_ready = 1'b0; Instruction = '0;
      alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;

      doReset(2);
      checkOutput("reset_state", int'(hist[1].state), 0);
      checkOutput("reset_halt", int'(hist[1].halt), 0);
      checkOutput("reset_memreq", int'(hist[1].mem_req), 0);

      hist.delete();
      runInstr(32'h002081B3, 0, 0, 0, 0, 0, tr);
      checkOutput("add_len", hist.size(), 4);
      checkOutput("add_op1", int'(hist[0].alu_op), 2);
      checkOutput("add_op2", int'(hist[1].alu_op), 2);
      checkOutput("add_op3", int'(hist[2].alu_op), 3);
      checkOutput("add_op4", int'(hist[3].alu_op), 0);
      checkOutput("add_rw3", int'(hist[2].reg_write), 0);
      checkOutput("add_rw4", int'(hist[3].reg_write), 1);
      checkOutput("add_ret4", int'(hist[3].retire), 1);

      hist.delete();
      runInstr(32'h0000A183, 0, 3, 0, 0, 0, tr);
      cnt = 0;
      for (int i = 3; i <= 6; i++) if (hist[i].mem_req && hist[i].addr_sel) cnt++;
      checkOutput("lw_len", hist.size(), 8);
      checkOutput("lw_memrd_held", cnt, 4);
      checkOutput("lw_wbsel", int'(hist[7].wb_sel), 1);
      checkOutput("lw_ret", int'(hist[7].retire), 1);

      hist.delete();
      runInstr(32'h00208063, 0, 0, 1, 0, 0, tr);
      checkOutput("beq_len", hist.size(), 3);
      checkOutput("beq_pcw", int'(hist[2].pc_write), 1);
      checkOutput("beq_pcsrc", int'(hist[2].pc_src), 1);
      hist.delete();
      runInstr(32'h00209063, 0, 0, 1, 0, 0, tr);
      checkOutput("bne_len", hist.size(), 3);
      checkOutput("bne_pcw", int'(hist[2].pc_write), 0);
      checkOutput("bne_ret", int'(hist[2].retire), 1);

      hist.delete();
      runInstr(32'h000080E7, 0, 0, 0, 0, 0, tr);
      cnt = 0;
      foreach (hist[i])
         if (hist[i].pc_write && hist[i].reg_write && hist[i].wb_sel == 2 && !hist[i].pc_src) cnt++;
      checkOutput("jalr_single", cnt, 1);

      runInstr(32'h00000000, 0, 0, 0, 0, 0, tr);
      hist.delete();
      for (int i = 0; i < 100; i++) applyStimulus(1, bit'($urandom_range(0, 1)), ph(15, 0, 0));
      cnt = 0; cnt2 = 0;
      foreach (hist[i]) begin
         if (hist[i].mem_req) cnt++;
         if (hist[i].halt) cnt2++;
      end
      checkOutput("trap_memreq", cnt, 0);
      checkOutput("trap_halt", cnt2, 100);
      doReset(1);
      hist.delete();
      applyStimulus(1, 0, ph(0, 0, 0));
      checkOutput("unhalt_state", int'(hist[0].state), 0);
      checkOutput("unhalt_halt", int'(hist[0].halt), 0);

      g_instr = 32'h0020A023;
      hist.delete();
      applyStimulus(1, 1, ph(0, 1, 0));
      applyStimulus(1, 0, ph(1, 0, 0));
      applyStimulus(1, 0, ph(5, 0, 0));
      applyStimulus(1, 0, ph(8, 0, 0));
      applyStimulus(1, 0, ph(8, 0, 0));
      applyStimulus(0, 1, '0);
      applyStimulus(0, 1, '0);
      applyStimulus(1, 0, ph(0, 0, 0));
      cnt = 0;
      foreach (hist[i]) if (hist[i].retire) cnt++;
      checkOutput("sw_rst_noretire", cnt, 0);
      checkOutput("sw_rst_allzero", int'(hist[5]), 0);
      checkOutput("sw_rst_fetch", int'(hist[7].mem_req), 1);

      hist.delete(); hist0.delete();
      runInstr(32'h00000073, 0, 0, 0, 0, 0, tr);
      checkOutput("ecall_trap", int'(hist[2].halt), 1);
      checkOutput("ecall0_retire", int'(hist0[1].retire), 1);
      checkOutput("ecall0_fetch", int'(hist0[2].state), 0);
      checkOutput("ecall0_memreq", int'(hist0[2].mem_req), 1);
      doReset(1);

      g_noise = 1'b1;
      for (int n = 0; n < 200; n++) begin
         k = $urandom_range(0, 39);
         r = $urandom();
         if (k < 36) op = legal_ops[k % 10];
         else if (k < 38) op = OPC_SYS;
         else begin
            op = 7'($urandom_range(0, 127));
            while (isLegal(op)) op = 7'($urandom_range(0, 127));
         end
         runInstr({r[31:7], op}, $urandom_range(0, 2), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tr);
         if (tr) begin
            for (int i = 0; i < 3; i++) applyStimulus(1, noise(), ph(15, 0, 0));
            doReset($urandom_range(1, 2));
         end
      end

      exp_valid = 1'b0;
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
